// File: rtl/sha2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_pkg
//  Description : Shared types and helpers for the SHA-2 message path:
//                mode encoding, block/length-field sizes, padding marker.
//  Revision    : 1.0  initial release
// ============================================================================
package sha2_pkg;

    typedef enum logic [1:0] {
        MODE_224 = 2'b00,
        MODE_256 = 2'b01,
        MODE_384 = 2'b10,
        MODE_512 = 2'b11
    } sha2_mode_t;

    // Leading one-bit of the padding, aligned to the first byte of a word
    localparam logic [31:0] PAD_WORD = 32'h8000_0000;

    // 32-bit words per block: 16 for the 512-bit family, 32 for the 1024-bit family
    function automatic logic [5:0] blk_words(input sha2_mode_t mode);
        return mode[1] ? 6'd32 : 6'd16;
    endfunction

    // 32-bit words in the trailing length field: 64-bit or 128-bit field
    function automatic logic [2:0] len_words(input sha2_mode_t mode);
        return mode[1] ? 3'd4 : 3'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha2_msg_pad.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_msg_pad
//  Description : Streams an unpadded message (32-bit big-endian words) and
//                emits it as FIPS 180-4 padded 512/1024-bit blocks, one
//                32-bit word per cycle, with block-last / message-last flags.
//  Revision    : 1.0  initial release
// ============================================================================
module sha2_msg_pad
    import sha2_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        clr_i,
    input  logic [1:0]  mode_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic [2:0]  in_nbytes_i,
    input  logic        in_last_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        out_blk_last_o,
    output logic        out_msg_last_o,
    output logic [1:0]  out_mode_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_PAD  = 3'd2,
        S_FILL = 3'd3,
        S_ZERO = 3'd4,
        S_LEN  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_wcnt;
    logic [LEN_W-1:0]  r_bitlen;
    sha2_mode_t        r_mode;

    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic              r_blk_last;
    logic              r_msg_last;
    sha2_mode_t        r_out_mode;

    logic              w_adv;
    logic              w_accept;
    sha2_mode_t        w_mode;
    logic [5:0]        w_blk_words;
    logic [5:0]        w_len_start;
    logic [5:0]        w_free;
    logic              w_at_end;
    logic [2:0]        w_nbytes_eff;
    logic [4:0]        w_shift;
    logic [31:0]       w_pad_data;
    state_t            w_pad_next;
    logic [127:0]      w_len_field;
    logic [31:0]       w_len_word;
    logic              w_load;
    logic [31:0]       w_data;
    logic              w_msg_last;

    // The output register can take a new word whenever it is empty or draining
    assign w_adv       = !r_out_valid || out_ready_i;
    assign in_ready_o  = ((r_state == S_IDLE) || (r_state == S_DATA)) && w_adv;
    // An abort in the same cycle wins over the handshake
    assign w_accept    = in_valid_i && in_ready_o && !clr_i;
    assign busy_o      = (r_state != S_IDLE);

    // Mode is taken live from the port until the first word latches it
    assign w_mode      = (r_state == S_IDLE) ? sha2_mode_t'(mode_i) : r_mode;
    assign w_blk_words = blk_words(w_mode);
    assign w_len_start = w_blk_words - {3'b000, len_words(w_mode)};
    assign w_free      = w_blk_words - 6'd1 - {1'b0, r_wcnt};
    assign w_at_end    = (w_free == 6'd0);

    // Malformed byte counts are handled as full words
    assign w_nbytes_eff = ((in_nbytes_i > 3'd4) || ((in_nbytes_i != 3'd4) && !in_last_i))
                          ? 3'd4 : in_nbytes_i;
    assign w_shift      = {w_nbytes_eff[1:0], 3'b000};
    assign w_pad_data   = (in_data_i & ~(32'hFFFF_FFFF >> w_shift)) | (PAD_WORD >> w_shift);

    // Route after the marker word: length fits in this block or spill to a new one
    assign w_pad_next = (w_free >= {3'b000, len_words(w_mode)})
                        ? ((w_free == {3'b000, len_words(w_mode)}) ? S_LEN : S_ZERO)
                        : (w_at_end ? S_ZERO : S_FILL);

    // Length field zero-extended; the word offset from the block end picks the slice
    always_comb begin
        w_len_field            = '0;
        w_len_field[LEN_W-1:0] = r_bitlen;
    end
    assign w_len_word = w_len_field[{w_free[1:0], 5'b00000} +: 32];

    // Next state and the word to place in the output register
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_data      = '0;
        w_msg_last  = 1'b0;
        case (r_state)
            S_IDLE, S_DATA: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_DATA;
                    w_data      = in_data_i;
                    if (in_last_i) begin
                        if (w_nbytes_eff == 3'd4) begin
                            w_state_nxt = S_PAD;
                        end else begin
                            w_data      = w_pad_data;
                            w_state_nxt = w_pad_next;
                        end
                    end
                end
            end
            S_PAD: begin
                if (w_adv) begin
                    w_load      = 1'b1;
                    w_data      = PAD_WORD;
                    w_state_nxt = w_pad_next;
                end
            end
            S_FILL: begin
                if (w_adv) begin
                    w_load = 1'b1;
                    if (w_at_end) w_state_nxt = S_ZERO;
                end
            end
            S_ZERO: begin
                if (w_adv) begin
                    w_load = 1'b1;
                    if (({1'b0, r_wcnt} + 6'd1) == w_len_start) w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_adv) begin
                    w_load = 1'b1;
                    w_data = w_len_word;
                    if (w_at_end) begin
                        w_msg_last  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counters and output register; abort clears everything in flight
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_bitlen    <= '0;
            r_mode      <= MODE_224;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_blk_last  <= 1'b0;
            r_msg_last  <= 1'b0;
            r_out_mode  <= MODE_224;
        end else if (clr_i) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_bitlen    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_blk_last  <= 1'b0;
            r_msg_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_bitlen <= ((r_state == S_IDLE) ? '0 : r_bitlen)
                            + LEN_W'({w_nbytes_eff, 3'b000});
                if (r_state == S_IDLE) r_mode <= sha2_mode_t'(mode_i);
            end
            if (w_load) begin
                r_wcnt <= w_at_end ? 5'd0 : r_wcnt + 5'd1;
            end
            if (w_adv) begin
                r_out_valid <= w_load;
                if (w_load) begin
                    r_out_data <= w_data;
                    r_blk_last <= w_at_end;
                    r_msg_last <= w_msg_last;
                    r_out_mode <= w_mode;
                end
            end
        end
    end

    assign out_valid_o    = r_out_valid;
    assign out_data_o     = r_out_data;
    assign out_blk_last_o = r_blk_last;
    assign out_msg_last_o = r_msg_last;
    assign out_mode_o     = r_out_mode;

endmodule
`default_nettype wire

// File: tb/tb_sha2_msg_pad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha2_msg_pad
//  Description : Self-checking bench for sha2_msg_pad. A byte-level padding
//                model fills an expected-word queue; a monitor pops and
//                compares every handshaken output word.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha2_msg_pad;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        clr_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data_i = '0;
    logic [2:0]  in_nbytes_i = 3'd0;
    logic        in_last_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_data_o;
    logic        out_blk_last_o;
    logic        out_msg_last_o;
    logic [1:0]  out_mode_o;
    logic        busy_o;

    sha2_msg_pad #(.LEN_W(64)) dut (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .clr_i          (clr_i),
        .mode_i         (mode_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .in_nbytes_i    (in_nbytes_i),
        .in_last_i      (in_last_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_blk_last_o (out_blk_last_o),
        .out_msg_last_o (out_msg_last_o),
        .out_mode_o     (out_mode_o),
        .busy_o         (busy_o)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [31:0] data;
        logic        blk_last;
        logic        msg_last;
        logic [1:0]  mode;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] msg[$];
    int         checks = 0;
    int         errors = 0;
    bit         bp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: pad the byte string per FIPS 180-4, then cut into words
    task automatic build_expected(input logic [1:0] mode);
        logic [7:0]  p[$];
        int          blk;
        int          lb;
        logic [63:0] bitlen;
        int          nwords;
        exp_t        e;
        p      = msg;
        blk    = mode[1] ? 128 : 64;
        lb     = mode[1] ? 16 : 8;
        bitlen = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % blk) != (blk - lb)) p.push_back(8'h00);
        for (int i = lb - 1; i >= 0; i--) p.push_back((i < 8) ? bitlen[8*i +: 8] : 8'h00);
        nwords = p.size() / 4;
        for (int w = 0; w < nwords; w++) begin
            e.data     = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
            e.blk_last = (((w + 1) % (blk / 4)) == 0);
            e.msg_last = (w == nwords - 1);
            e.mode     = mode;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [31:0] make_word(input int idx, input int nb);
        logic [31:0] w;
        for (int b = 0; b < 4; b++)
            w[31-8*b -: 8] = (b < nb) ? msg[idx+b] : 8'($urandom);
        return w;
    endfunction

    // Offer one word and hold it until accepted (entered/left at posedge+1)
    task automatic drive_word(input logic [1:0] md, input logic [31:0] d,
                              input logic [2:0] nb, input logic last);
        int  cyc;
        bit  ok;
        mode_i      = md;
        in_valid_i  = 1'b1;
        in_data_i   = d;
        in_nbytes_i = nb;
        in_last_i   = last;
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < 1000) begin
            @(negedge hclk);
            ok = in_ready_o;
            cyc++;
            if (!ok) @(posedge hclk);
        end
        if (!ok) check("in_ready_timeout", 64'(in_ready_o), 64'd1);
        @(posedge hclk);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        mode_i     = 2'($urandom);
    endtask

    // Issue msg[] as a stream; optionally close a word-aligned message with n=0
    task automatic send_msg(input logic [1:0] mode, input bit zero_last, input int max_words);
        int   n;
        int   idx;
        int   chunk;
        int   sent;
        logic last;
        n    = msg.size();
        idx  = 0;
        sent = 0;
        build_expected(mode);
        while (idx < n && sent < max_words) begin
            chunk = (n - idx >= 4) ? 4 : n - idx;
            last  = ((idx + chunk) == n) && !(zero_last && chunk == 4);
            drive_word((sent == 0) ? mode : 2'($urandom), make_word(idx, chunk), 3'(chunk), last);
            idx += chunk;
            sent++;
        end
        if (sent < max_words && (n == 0 || (zero_last && (n % 4) == 0)))
            drive_word((sent == 0) ? mode : 2'($urandom), $urandom, 3'd0, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(posedge hclk);
            c++;
        end
        #1;
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        @(posedge hclk);
        #1;
        check({name, "_idle"}, {62'd0, busy_o, out_valid_o}, 64'd0);
    endtask

    task automatic fill_msg(input int n, input bit incr);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(incr ? 8'(i) : 8'($urandom));
    endtask

    // Downstream ready: constantly high or random per cycle
    initial begin
        forever begin
            @(posedge hclk);
            #1;
            out_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare every accepted output word and check stall stability
    exp_t mon_prev;
    bit   mon_stall = 1'b0;
    bit   mon_clr = 1'b0;
    exp_t mon_cur;
    initial begin
        forever begin
            @(negedge hclk);
            if (hresetn) begin
                mon_cur = {out_data_o, out_blk_last_o, out_msg_last_o, out_mode_o};
                if (mon_stall && !mon_clr)
                    check("stall_hold", {27'd0, out_valid_o, mon_cur}, {27'd0, 1'b1, mon_prev});
                if (out_valid_o && out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {28'd0, mon_cur}, 64'd0);
                    end else begin
                        check("word", {28'd0, mon_cur}, {28'd0, exp_q.pop_front()});
                    end
                end
                mon_stall = out_valid_o && !out_ready_i;
                mon_prev  = mon_cur;
                mon_clr   = clr_i;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge hclk);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_outs", {26'd0, out_data_o, out_blk_last_o, out_msg_last_o, out_mode_o}, 64'd0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // SHA-256 "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(2'b01, 1'b0, 1000);
        wait_drain("abc");

        // SHA-256 55 bytes: pad and length share one block
        fill_msg(55, 1'b1);
        send_msg(2'b01, 1'b0, 1000);
        wait_drain("len55");

        // SHA-256 56 bytes: spills into a second block
        fill_msg(56, 1'b1);
        send_msg(2'b01, 1'b0, 1000);
        wait_drain("len56");

        // SHA-512 empty message
        msg.delete();
        send_msg(2'b11, 1'b0, 1000);
        wait_drain("empty512");

        // 56 bytes again under random backpressure
        bp_en = 1'b1;
        fill_msg(56, 1'b1);
        send_msg(2'b01, 1'b0, 1000);
        wait_drain("len56_bp");
        bp_en = 1'b0;
        @(posedge hclk);
        #1;

        // Abort mid-message, with a word offered in the abort cycle
        fill_msg(55, 1'b1);
        send_msg(2'b01, 1'b0, 6);
        @(negedge hclk);
        check("busy_mid_msg", 64'(busy_o), 64'd1);
        @(posedge hclk);
        #1;
        clr_i       = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hDEAD_BEEF;
        in_nbytes_i = 3'd4;
        in_last_i   = 1'b0;
        @(posedge hclk);
        #1;
        clr_i      = 1'b0;
        in_valid_i = 1'b0;
        exp_q.delete();
        @(negedge hclk);
        check("busy_after_clr", {62'd0, busy_o, out_valid_o}, 64'd0);
        @(posedge hclk);
        #1;
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(2'b01, 1'b0, 1000);
        wait_drain("abc_after_clr");

        // Randomized messages: length, mode, backpressure, closing style
        for (int t = 0; t < 20; t++) begin
            bp_en = 1'($urandom_range(0, 1));
            fill_msg($urandom_range(0, 200), 1'b0);
            send_msg(2'($urandom), 1'($urandom_range(0, 1)), 1000);
            wait_drain("rand");
        end
        bp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
